// File: rtl/stream_reader.sv
// Strided memory reader: fetches COUNT words from START by STRIDE and streams them out
// through a credit-limited FIFO. Define STREAM_READER_REPEAT_EN to add the REPEAT port.
//
// state  | meaning
// IDLE   | waiting for GO; transfer parameters latched when it arrives
// RUN    | issuing reads under FIFO credit and delivering beats
// FINISH | one-cycle DONE pulse, then back to IDLE
module stream_reader #(
    parameter int DWIDTH     = 8,
    parameter int AWIDTH     = 32,
    parameter int CWIDTH     = 16,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              GO,
    input  logic [AWIDTH-1:0] START,
    input  logic [CWIDTH-1:0] COUNT,
    input  logic [AWIDTH-1:0] STRIDE,
`ifdef STREAM_READER_REPEAT_EN
    input  logic              REPEAT,
`endif
    output logic              BUSY,
    output logic              DONE,
    output logic [AWIDTH-1:0] ADDR,
    output logic              REN,
    input  logic [DWIDTH-1:0] DATAI,
    output logic [DWIDTH-1:0] DATAO,
    output logic              VALID,
    input  logic              READY,
    output logic              LAST
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int OW   = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
    localparam int PAW  = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   start_q, start_d;
    logic [AWIDTH-1:0]   stride_q, stride_d;
    logic [CWIDTH-1:0]   count_q, count_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [CWIDTH-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CWIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [DWIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [DWIDTH-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [PAW-1:0]      pass_ahead_q, pass_ahead_d;

    logic                ren;
    logic                push;
    logic                pop;
    logic                fifo_valid;
    logic                credit_ok;
    logic                repeat_active;
    logic                pass_inc;
    logic                pass_dec;
    logic [OW-1:0]       inflight;
    logic [OW-1:0]       occupancy;

`ifdef STREAM_READER_REPEAT_EN
    logic repeat_q, repeat_d;
    assign repeat_active = repeat_q & REPEAT;
`else
    assign repeat_active = 1'b0;
`endif

    assign fifo_valid = (fifo_cnt_q != '0);
    assign pop        = fifo_valid & READY;
    assign push       = pipe_q[RD_LATENCY-1];

    // Credit counts reads still in the memory pipe plus stored words, minus this cycle's pop.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + OW'(pipe_q[i]);
        end
        occupancy = inflight + OW'(fifo_cnt_q) - OW'(pop);
        credit_ok = (occupancy < OW'(FIFO_DEPTH));
    end

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        stride_d    = stride_q;
        count_d     = count_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        ren         = 1'b0;
        pass_inc    = 1'b0;
        pass_dec    = 1'b0;
        pass_ahead_d = pass_ahead_q;
`ifdef STREAM_READER_REPEAT_EN
        repeat_d    = repeat_q & REPEAT;
`endif

        case (state_q)
            IDLE: begin
                if (GO) begin
                    start_d      = START;
                    stride_d     = STRIDE;
                    count_d      = COUNT;
                    addr_d       = START;
                    issue_cnt_d  = COUNT;
                    beat_cnt_d   = COUNT;
                    pass_ahead_d = '0;
`ifdef STREAM_READER_REPEAT_EN
                    repeat_d     = REPEAT;
`endif
                    state_d      = (COUNT == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                ren = (issue_cnt_q != '0) && credit_ok;
                if (ren) begin
                    if ((issue_cnt_q == CWIDTH'(1)) && repeat_active) begin
                        issue_cnt_d = count_q;
                        addr_d      = start_q;
                        pass_inc    = 1'b1;
                    end else begin
                        issue_cnt_d = issue_cnt_q - CWIDTH'(1);
                        addr_d      = addr_q + stride_q;
                    end
                end
                // A pass already issued ahead keeps the stream going past this LAST beat.
                if (pop) begin
                    if (beat_cnt_q == CWIDTH'(1)) begin
                        if (pass_ahead_q != '0) begin
                            beat_cnt_d = count_q;
                            pass_dec   = 1'b1;
                        end else begin
                            state_d    = FINISH;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q - CWIDTH'(1);
                    end
                end
                pass_ahead_d = pass_ahead_q + PAW'(pass_inc) - PAW'(pass_dec);
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pipe_d[0] = ren;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = DATAI;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        fifo_cnt_d = fifo_cnt_q + CNTW'(push) - CNTW'(pop);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            start_q      <= '0;
            stride_q     <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            issue_cnt_q  <= '0;
            beat_cnt_q   <= '0;
            pipe_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            pass_ahead_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef STREAM_READER_REPEAT_EN
            repeat_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            stride_q     <= stride_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            issue_cnt_q  <= issue_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            pipe_q       <= pipe_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            pass_ahead_q <= pass_ahead_d;
            mem_q        <= mem_d;
`ifdef STREAM_READER_REPEAT_EN
            repeat_q     <= repeat_d;
`endif
        end
    end

    assign BUSY  = (state_q != IDLE);
    assign DONE  = (state_q == FINISH);
    assign ADDR  = addr_q;
    assign REN   = ren;
    assign DATAO = mem_q[rd_ptr_q];
    assign VALID = fifo_valid;
    assign LAST  = fifo_valid && (beat_cnt_q == CWIDTH'(1));

endmodule

// File: tb/tb_stream_reader.sv
// Directed bench for stream_reader: scoreboarded beats and addresses, credit model,
// DONE timing, stall stability, zero length, address wrap and reset abort.
module tb_stream_reader;

    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int CW    = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic          fin;
    } beat_t;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic          GO = 1'b0;
    logic [AW-1:0] START = '0;
    logic [CW-1:0] COUNT = '0;
    logic [AW-1:0] STRIDE = '0;
    logic          BUSY, DONE, REN, VALID, LAST;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] DATAI, DATAO;
    logic          READY = 1'b1;
`ifdef STREAM_READER_REPEAT_EN
    logic          REPEAT = 1'b0;
`endif

    int  checks = 0;
    int  failures = 0;
    int  cyc_n = 0;
    int  go_cyc = 0;
    int  done_expect = -1;
    int  dones = 0;
    int  rens = 0;
    int  beats = 0;
    int  issued = 0;
    int  popped = 0;
    int  total = 0;
    bit  check_ren = 1'b1;
    bit  first_pending = 1'b0;
    bit  prev_stall = 1'b0;
    bit  prev_done = 1'b0;
    logic [DW-1:0] prev_data = '0;
    beat_t         sb[$];
    logic [AW-1:0] aq[$];
    logic [DW-1:0] rd_pipe [LAT];

    always #5 CLOCK = ~CLOCK;

    stream_reader #(
        .DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .GO(GO), .START(START), .COUNT(COUNT),
        .STRIDE(STRIDE),
`ifdef STREAM_READER_REPEAT_EN
        .REPEAT(REPEAT),
`endif
        .BUSY(BUSY), .DONE(DONE), .ADDR(ADDR), .REN(REN), .DATAI(DATAI),
        .DATAO(DATAO), .VALID(VALID), .READY(READY), .LAST(LAST)
    );

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Synchronous-read memory with LAT cycles of latency; zero when not read.
    always @(posedge CLOCK) begin
        rd_pipe[0] <= (REN === 1'b1) ? mdata(ADDR) : '0;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign DATAI = rd_pipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        bit            pop;
        logic          exp_ren;
        beat_t         e;
        logic [AW-1:0] ea;
        @(negedge CLOCK);
        pop = (VALID === 1'b1) && (READY === 1'b1);
        if (check_ren) begin
            exp_ren = (BUSY === 1'b1) && (issued < total) &&
                      ((issued - popped - int'(pop)) < DEPTH);
            chk("ren_credit", REN, exp_ren);
        end
        if (REN === 1'b1) begin
            rens++;
            issued++;
            chk("ren_expected", aq.size() > 0, 1);
            if (aq.size() > 0) begin
                ea = aq.pop_front();
                chk("addr", ADDR, ea);
            end
        end
        if (prev_stall) chk("stall_hold", {VALID, DATAO}, {1'b1, prev_data});
        if ((VALID === 1'b1) && first_pending) begin
            chk("first_latency", cyc_n - go_cyc, LAT + 2);
            first_pending = 1'b0;
        end
        if (pop) begin
            chk("beat_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("data", DATAO, e.d);
                chk("last", LAST, e.last);
                if (e.fin) done_expect = cyc_n + 1;
            end
            popped++;
            beats++;
        end
        if ((DONE === 1'b1) || (cyc_n == done_expect))
            chk("done_cycle", {DONE, cyc_n == done_expect}, 2'b11);
        if (DONE === 1'b1) dones++;
        if (prev_done) chk("busy_after_done", BUSY, 0);
        prev_done  = (DONE === 1'b1);
        prev_stall = (VALID === 1'b1) && (READY !== 1'b1);
        prev_data  = DATAO;
        @(posedge CLOCK);
        #1;
        cyc_n++;
    endtask

    task automatic start_xfer(input logic [AW-1:0] s, input logic [CW-1:0] c,
                              input logic [AW-1:0] st, input int passes);
        logic [AW-1:0] a;
        issued = 0;
        popped = 0;
        total  = int'(c) * passes;
        for (int p = 0; p < passes; p++) begin
            a = s;
            for (int i = 0; i < int'(c); i++) begin
                aq.push_back(a);
                sb.push_back('{mdata(a), i == int'(c) - 1, (p == passes - 1) && (i == int'(c) - 1)});
                a = a + st;
            end
        end
        START = s;
        COUNT = c;
        STRIDE = st;
        GO = 1'b1;
        go_cyc = cyc_n;
        first_pending = (c != '0);
        if (c == '0) done_expect = cyc_n + 1;
        cyc();
        GO = 1'b0;
        START = 16'hDEAD;
        COUNT = 8'd7;
        STRIDE = 16'h0033;
    endtask

    task automatic run_xfer(input int max, input bit bp, input bit go_busy, input bit go_fin);
        int d0;
        int n;
        d0 = dones;
        n = 0;
        while ((dones == d0) && (n < max)) begin
            if (bp) READY = ((n % 4) == 0) || ((n % 4) == 3);
            GO = 1'b0;
            if (go_busy && (n == 2)) begin
                GO = 1'b1;
                START = 16'h0999;
                COUNT = 8'd3;
            end
            if (go_fin && (cyc_n == done_expect)) begin
                GO = 1'b1;
                START = 16'h0777;
                COUNT = 8'd5;
            end
            cyc();
            n++;
        end
        GO = 1'b0;
        READY = 1'b1;
        chk("done_seen", dones - d0, 1);
    endtask

    initial begin
        int d0;
        int b0;
        int r0;
        int n;

        repeat (2) @(posedge CLOCK);
        #1;
        chk("reset_outputs", {BUSY, DONE, REN, VALID, LAST, ADDR, DATAO}, 0);
        RESET = 1'b1;
        cyc();

        // Basic pass, with a GO in the FINISH cycle that must be ignored.
        start_xfer(16'h0100, 8'd4, 16'h0004, 1);
        run_xfer(60, 1'b0, 1'b0, 1'b1);
        cyc();
        cyc();
        chk("basic_sb_empty", sb.size(), 0);

        // Back-pressure with READY 1-0-0-1 and an ignored GO while busy.
        start_xfer(16'h0040, 8'd8, 16'h0003, 1);
        run_xfer(200, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("bp_sb_empty", sb.size(), 0);

        // Zero length.
        b0 = beats;
        r0 = rens;
        start_xfer(16'h0500, 8'd0, 16'h0001, 1);
        run_xfer(10, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("zero_no_beats", beats - b0, 0);
        chk("zero_no_ren", rens - r0, 0);

        // Address wrap.
        start_xfer(16'hFFFC, 8'd4, 16'h0002, 1);
        run_xfer(60, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("wrap_aq_empty", aq.size(), 0);

        // Reset mid-transfer after three beats.
        start_xfer(16'h0300, 8'd8, 16'h0001, 1);
        n = 0;
        while ((popped < 3) && (n < 50)) begin
            cyc();
            n++;
        end
        chk("reached_3_beats", popped, 3);
        #2;
        RESET = 1'b0;
        #1;
        chk("reset_async", {BUSY, DONE, REN, VALID, LAST, ADDR, DATAO}, 0);
        sb.delete();
        aq.delete();
        prev_stall = 1'b0;
        first_pending = 1'b0;
        done_expect = -1;
        issued = 0;
        popped = 0;
        total = 0;
        d0 = dones;
        cyc();
        cyc();
        RESET = 1'b1;
        cyc();
        cyc();
        chk("no_done_after_reset", dones - d0, 0);
        start_xfer(16'h0200, 8'd5, 16'h0008, 1);
        run_xfer(80, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("restart_sb_empty", sb.size(), 0);

`ifdef STREAM_READER_REPEAT_EN
        // Repeat: three passes of three words, LAST every third beat, one DONE.
        check_ren = 1'b0;
        d0 = dones;
        b0 = beats;
        r0 = rens;
        REPEAT = 1'b1;
        start_xfer(16'h0010, 8'd3, 16'h0001, 3);
        n = 0;
        while ((dones == d0) && (n < 100)) begin
            if ((rens - r0) >= 6) REPEAT = 1'b0;
            cyc();
            n++;
        end
        REPEAT = 1'b0;
        cyc();
        chk("repeat_beats", beats - b0, 9);
        chk("repeat_dones", dones - d0, 1);
        chk("repeat_sb_empty", sb.size(), 0);
        check_ren = 1'b1;
`endif

        chk("final_aq_empty", aq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
